// File: rtl/online_mult_sched_pkg.sv
// Shared state encoding, default sizing and precision clamp for the
// online multiplier scheduler.
package online_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      COMP = 3'd2,
      REST = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam int DEF_DIGIT_W      = 2;
   localparam int DEF_MAX_UNROLL   = 64;
   localparam int DEF_ONLINE_DELAY = 2;

   // A zero request still needs one digit of work; oversize requests saturate.
   function automatic int unsigned clamp_precision(input int unsigned prec,
                                                   input int unsigned max_n);
      if (prec == 0)
         return 1;
      if (prec > max_n)
         return max_n;
      return prec;
   endfunction

endpackage

// File: rtl/online_mult_sched_rest_counter.sv
// Loadable down-counter with hold for the REST replay phase; exposes the
// replay address (rest-1) and a flag for the final replay cycle.
module online_rest_counter #(
   parameter int CNT_WIDTH  = 11,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  asyn_reset,
   input  logic                  load_i,
   input  logic                  dec_i,
   input  logic [CNT_WIDTH-1:0]  load_val_i,
   output logic [CNT_WIDTH-1:0]  rest_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  last_o
);

   logic [CNT_WIDTH-1:0] rest_q;

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset)
         rest_q <= '0;
      else if (load_i)
         rest_q <= load_val_i;
      else if (dec_i)
         rest_q <= rest_q - CNT_WIDTH'(1);
   end

   assign rest_o    = rest_q;
   assign rd_addr_o = ADDR_WIDTH'(rest_q - CNT_WIDTH'(1));
   assign last_o    = (rest_q == CNT_WIDTH'(1));

endmodule

// File: rtl/online_mult_sched.sv
// Scheduler for the serial online multiplier: loads N+D digit pairs, then
// runs one COMP cycle plus k REST replay cycles for each step k = 1..N.
module online_mult_sched
   import online_pkg::*;
#(
   parameter int DIGIT_W      = DEF_DIGIT_W,
   parameter int MAX_UNROLL   = DEF_MAX_UNROLL,
   parameter int ONLINE_DELAY = DEF_ONLINE_DELAY,
   parameter int ADDR_WIDTH   = 7,
   parameter int CNT_WIDTH    = 11
) (
   input  logic                  clk,
   input  logic                  asyn_reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  precision,
   input  logic                  stall,
   input  logic [DIGIT_W-1:0]    x_in,
   input  logic [DIGIT_W-1:0]    y_in,
   output logic [DIGIT_W-1:0]    x_value,
   output logic [DIGIT_W-1:0]    y_value,
   output logic                  busy,
   output logic                  done,
   output logic                  enable,
   output logic                  add_enable,
   output logic                  res_enable,
   output logic                  finish_vec,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [CNT_WIDTH-1:0]  counter,
   output logic [CNT_WIDTH-1:0]  shift_cnt,
   output logic [CNT_WIDTH-1:0]  step
);
   // state | meaning
   // IDLE  | waiting for start, all outputs low
   // LOAD  | latching N+D digit pairs, then one transition cycle
   // COMP  | first cycle of step k, a new digit pair enters
   // REST  | k replay cycles reading stored digits k-1 down to 0
   // DONE  | one-cycle completion pulse, returns to IDLE

   if ((2 ** ADDR_WIDTH) < MAX_UNROLL) begin : g_addr_chk
      $error("ADDR_WIDTH cannot address MAX_UNROLL digits");
   end
   if ((2 ** CNT_WIDTH) <= (MAX_UNROLL + ONLINE_DELAY)) begin : g_cnt_chk
      $error("CNT_WIDTH too small for MAX_UNROLL + ONLINE_DELAY");
   end

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] n_q, n_d, counter_q, counter_d, step_q, step_d;
   logic [DIGIT_W-1:0]   x_q, x_d, y_q, y_d;
   logic                 rest_load, rest_dec, rest_last;
   logic [CNT_WIDTH-1:0] rest_load_val, rest;
   logic [ADDR_WIDTH-1:0] rest_addr;
   logic [CNT_WIDTH-1:0] load_end;

   assign load_end = n_q + CNT_WIDTH'(ONLINE_DELAY);

   online_rest_counter #(
      .CNT_WIDTH  (CNT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rest (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .load_i     (rest_load),
      .dec_i      (rest_dec),
      .load_val_i (rest_load_val),
      .rest_o     (rest),
      .rd_addr_o  (rest_addr),
      .last_o     (rest_last)
   );

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      counter_d     = counter_q;
      step_d        = step_q;
      x_d           = x_q;
      y_d           = y_q;
      rest_load     = 1'b0;
      rest_dec      = 1'b0;
      rest_load_val = step_q;
      case (state_q)
         IDLE: if (start) begin
            n_d       = CNT_WIDTH'(clamp_precision(32'(precision), MAX_UNROLL));
            counter_d = '0;
            step_d    = '0;
            state_d   = LOAD;
         end
         LOAD: if (!stall) begin
            if (counter_q < load_end) begin
               x_d       = x_in;
               y_d       = y_in;
               counter_d = counter_q + CNT_WIDTH'(1);
            end else begin
               counter_d     = '0;
               step_d        = CNT_WIDTH'(1);
               rest_load     = 1'b1;
               rest_load_val = CNT_WIDTH'(1);
               state_d       = COMP;
            end
         end
         COMP: if (!stall) begin
            x_d       = x_in;
            y_d       = y_in;
            rest_load = 1'b1;
            state_d   = REST;
         end
         REST: if (!stall) begin
            if (!rest_last)
               rest_dec = 1'b1;
            else if (step_q == n_q)
               state_d = DONE;
            else begin
               step_d  = step_q + CNT_WIDTH'(1);
               state_d = COMP;
            end
         end
         DONE: begin
            // Clear the visible registers so IDLE presents all-zero outputs.
            step_d  = '0;
            x_d     = '0;
            y_d     = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state_q   <= IDLE;
         n_q       <= '0;
         counter_q <= '0;
         step_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         counter_q <= counter_d;
         step_q    <= step_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   always_comb begin
      busy       = (state_q != IDLE);
      done       = (state_q == DONE);
      enable     = 1'b0;
      add_enable = 1'b0;
      res_enable = 1'b0;
      finish_vec = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      shift_cnt  = '0;
      case (state_q)
         LOAD: begin
            enable     = !stall;
            res_enable = 1'b1;
            finish_vec = (counter_q == load_end - CNT_WIDTH'(1));
            shift_cnt  = (counter_q < n_q) ? (n_q - counter_q) : '0;
         end
         COMP: begin
            enable     = !stall;
            add_enable = !stall;
            res_enable = 1'b1;
            rd_en      = !stall && (rest != '0);
            rd_addr    = ADDR_WIDTH'(step_q - CNT_WIDTH'(1));
            shift_cnt  = n_q - step_q;
         end
         REST: begin
            add_enable = !stall && rest_last;
            res_enable = 1'b1;
            rd_en      = !stall && (rest != '0);
            rd_addr    = rest_addr;
            shift_cnt  = n_q - step_q;
         end
         default: ;
      endcase
   end

   assign counter = counter_q;
   assign step    = step_q;
   assign x_value = x_q;
   assign y_value = y_q;

endmodule

// File: doc/online_mult_sched.md
Name: online_mult_sched

Overview:
- Parametrised scheduler for the serial online (MSD-first, signed-digit) multiplier in the Newton datapath.
- Loads N operand digit pairs plus the online delay, then runs N compute steps. Step k issues one COMP cycle followed by k REST cycles that replay stored partial-product digits at addresses k-1 down to 0.
- Adds a start/done handshake, runtime precision, stall and termination.

Parameters:
- DIGIT_W, 2, width of one signed digit (x_in/y_in).
- MAX_UNROLL, 64, maximum precision N in digits.
- ONLINE_DELAY, 2, online delay D in cycles.
- ADDR_WIDTH, 7, digit-memory address width; 2^ADDR_WIDTH >= MAX_UNROLL (elaboration check).
- CNT_WIDTH, 11, width of counters; 2^CNT_WIDTH > MAX_UNROLL+ONLINE_DELAY (elaboration check).

Ports:
- clk  in  1  clock, rising edge.
- asyn_reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin operation; accepted only in IDLE.
- precision  in  CNT_WIDTH  requested N; sampled on the accepted start.
- stall  in  1  freeze schedule for this cycle.
- x_in, y_in  in  DIGIT_W  operand digits.
- x_value, y_value  out  DIGIT_W  registered latched digits.
- busy  out  1  high from the cycle after start until DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- enable  out  1  datapath digit enable.
- add_enable  out  1  accumulate enable.
- res_enable  out  1  result register enable.
- finish_vec  out  1  last-load-cycle flag.
- rd_en  out  1  digit memory read strobe.
- rd_addr  out  ADDR_WIDTH  digit memory read address.
- counter  out  CNT_WIDTH  load-phase counter.
- shift_cnt  out  CNT_WIDTH  significance of the current digit.
- step  out  CNT_WIDTH  current step k.

Behaviour:
- Reset (async, any state): state=IDLE; counter, step, rest, N, x_value, y_value = 0; every output 0.
- States: IDLE, LOAD, COMP, REST, DONE.
- IDLE: all outputs 0. On start=1, N <= clamp(precision, 1, MAX_UNROLL) (0 maps to 1, above MAX_UNROLL maps to MAX_UNROLL); counter <= 0; step <= 0; go to LOAD. stall is ignored in IDLE.
- LOAD, while counter < N+D:
  - x_value <= x_in, y_value <= y_in, counter++.
  - enable = 1, res_enable = 1, rd_en = 0, add_enable = 0.
  - shift_cnt = N - counter, saturating at 0.
  - finish_vec = 1 only when counter == N+D-1.
- LOAD, counter == N+D (transition cycle): no digit latch, enable = 1; counter <= 0, step <= 1, rest <= 1, go to COMP.
- COMP (1 cycle):
  - Latch x_value/y_value.
  - enable = 1, add_enable = 1, rd_en = 1.
  - rd_addr = step-1, shift_cnt = N - step.
  - Next: REST with rest = step.
- REST (step cycles):
  - enable = 0, rd_en = 1, rd_addr = rest-1; rest decrements each cycle.
  - add_enable = 1 only on the cycle with rest == 1 (rd_addr = 0).
  - shift_cnt = N - step.
  - After the rest == 1 cycle: if step == N go to DONE, else step++ and go to COMP.
- DONE (1 cycle): done = 1, busy = 1, other strobes 0; next state IDLE. A start in the DONE cycle is ignored.
- stall = 1 in LOAD/COMP/REST:
  - All registers hold.
  - enable, add_enable and rd_en are forced to 0.
  - rd_addr, shift_cnt and step keep their held values.
- res_enable = 1 in LOAD, COMP and REST, otherwise 0.
- start while busy is ignored; precision is not re-sampled mid-operation.
- Latency: busy spans (N+D+1) + sum over k=1..N of (k+1), plus 1 for DONE, non-stalled cycles.
- Arithmetic:
  - All counters are unsigned CNT_WIDTH.
  - rd_addr is the low ADDR_WIDTH bits of rest-1, with rest >= 1 guaranteed.
  - No wrap is reachable given the elaboration checks.

Decomposition:
- Package online_pkg:
  - State enum (IDLE=0, LOAD=1, COMP=2, REST=3, DONE=4; 3-bit).
  - Default DIGIT_W, MAX_UNROLL and ONLINE_DELAY constants.
  - A clamp function for precision.
- One sub-module, online_rest_counter: loadable down-counter with hold. It outputs rest, rd_addr = rest-1, and a last flag (rest == 1).

Test Plan:
- N=4, D=2, no stall:
  - busy for 22 cycles and done pulses exactly once.
  - finish_vec is high at counter=5.
  - rd_addr sequence: step1 {0, 0}, step2 {1, 1, 0}, step3 {2, 2, 1, 0}, step4 {3, 3, 2, 1, 0}.
  - add_enable is high on every COMP cycle and on every rd_addr=0 REST cycle.
- precision=0 gives N=1: 4 LOAD cycles, COMP, one REST at rd_addr=0, DONE. precision=100 gives N=64 and shift_cnt starts at 64.
- stall held 3 cycles during step3 REST at rd_addr=1: rd_addr stays 1, rd_en=0 and add_enable=0 while stalled; the sequence resumes at 1, then 0; total busy grows by exactly 3.
- start pulsed during LOAD and again in the DONE cycle: both ignored; start in the following IDLE cycle is accepted.
- asyn_reset asserted mid-REST of step2 (not clock-aligned): all outputs 0 immediately. After release, a new start with N=2 completes normally in 2+2+1+(2+3)+1 = 11 busy cycles.
- Digit capture: x_in/y_in = 2'b01/2'b11 in the LOAD cycle with counter=3 appear on x_value/y_value in the next cycle; values are not updated during REST.
